// File: rtl/bcd_2_binary.sv
// Two-digit BCD to 7-bit binary converter (reverse double dabble, one bit per clock).
// Optional macro BCD_DIGIT_CHECK_EN adds an err output and rejects digits above 9.
module bcd_2_binary (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] bcd1,
   input  logic [3:0] bcd2,
   output logic       busy,
   output logic       done_tick,
   output logic [6:0] bin
`ifdef BCD_DIGIT_CHECK_EN
   ,
   output logic       err
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OP   = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [7:0]  r_sh;
   logic [6:0]  r_acc;
   logic [2:0]  r_n;
   logic [6:0]  r_bin;
   logic        r_busy;
   logic        r_done_tick;
   logic [7:0]  w_shr;
   logic [7:0]  w_sh_next;
   logic [6:0]  w_acc_next;
   logic        w_digit_bad;
   logic        w_last;
`ifdef BCD_DIGIT_CHECK_EN
   logic        r_err;
`endif

   // Undo the doubling correction: a nibble that shifted in a tens bit reads >= 8.
   function automatic logic [3:0] fix_nibble(input logic [3:0] x);
      fix_nibble = (x >= 4'd8) ? (x - 4'd3) : x;
   endfunction

   // Datapath next values and range check.
   always_comb begin
      w_shr      = {1'b0, r_sh[7:1]};
      w_sh_next  = {fix_nibble(w_shr[7:4]), fix_nibble(w_shr[3:0])};
      w_acc_next = {r_sh[0], r_acc[6:1]};
      w_last     = (r_n == 3'd1);
`ifdef BCD_DIGIT_CHECK_EN
      w_digit_bad = (bcd1 > 4'd9) || (bcd2 > 4'd9);
`else
      w_digit_bad = 1'b0;
`endif
   end

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (w_digit_bad) begin
                  w_state_next = S_DONE;
               end else begin
                  w_state_next = S_OP;
               end
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_OP: begin
            if (w_last) begin
               w_state_next = S_DONE;
            end else begin
               w_state_next = S_OP;
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // State register plus flags registered from the next state so they align with it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_busy      <= 1'b0;
         r_done_tick <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_busy      <= (w_state_next != S_IDLE);
         r_done_tick <= (w_state_next == S_DONE);
      end
   end

   // Shift/accumulate datapath; bin only updates on completion.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sh  <= 8'd0;
         r_acc <= 7'd0;
         r_n   <= 3'd0;
         r_bin <= 7'd0;
`ifdef BCD_DIGIT_CHECK_EN
         r_err <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_sh  <= {bcd2, bcd1};
                  r_acc <= 7'd0;
                  r_n   <= 3'd7;
`ifdef BCD_DIGIT_CHECK_EN
                  r_err <= w_digit_bad;
                  if (w_digit_bad) begin
                     r_bin <= 7'h7F;
                  end
`endif
               end
            end
            S_OP: begin
               r_sh  <= w_sh_next;
               r_acc <= w_acc_next;
               r_n   <= r_n - 3'd1;
               if (w_last) begin
                  r_bin <= w_acc_next;
               end
            end
            default: begin
               r_n <= r_n;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done_tick = r_done_tick;
   assign bin       = r_bin;
`ifdef BCD_DIGIT_CHECK_EN
   assign err       = r_err;
`endif

endmodule
